// File: rtl/fifo8_burst_reader_pkg.sv
// Shared types and constants for the FIFO_8 burst reader.
package fifo8_burst_reader_pkg;

  localparam int FIFO_DATA_W   = 8;
  localparam int BURST_LEN_W   = 4;
  localparam int RETRY_MAX_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fifo8_burst_reader_sat_cnt8.sv
// 8-bit saturating event counter (used for the underflow count).
module sat_cnt8
  import fifo8_burst_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_inc,
  output logic [7:0] o_cnt
);

  logic [7:0] r_cnt;

  // Count events, holding at 255 once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (i_inc) begin
      r_cnt <= sat_inc8(r_cnt);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fifo8_burst_reader.sv
// Read-side burst controller for FIFO_8: drains N bytes, retries empty
// reads, and presents each byte on a valid/ready stream.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; timeout and sum hold last burst's result
// ISSUE | fifo_ren high for this one cycle
// WAIT  | FIFO answers; byte captured or error counted / retried
// HOLD  | out_valid high until the consumer takes the byte
// DONE  | one-cycle done pulse, then back to IDLE
module fifo8_burst_reader
  import fifo8_burst_reader_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int LEN_W     = BURST_LEN_W,
  parameter int RETRY_MAX = RETRY_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] sum,
  output logic [7:0]        underflow_cnt,
  output logic              fifo_ren,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_error,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  // Retry counter only needs to reach RETRY_MAX-1; the next error aborts.
  localparam int RETRY_W = (RETRY_MAX > 1) ? $clog2(RETRY_MAX) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_MAX - 1);

  state_t              r_state;
  logic [LEN_W-1:0]    r_rem;
  logic [RETRY_W-1:0]  r_retry;
  logic                r_timeout;
  logic [DATA_W-1:0]   r_sum;
  logic [DATA_W-1:0]   r_out_data;
  logic                w_err_read;

  // An error read is only meaningful in the cycle right after our ren.
  assign w_err_read = (r_state == ST_WAIT) && fifo_error;

  sat_cnt8 u_underflow (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_err_read),
    .o_cnt (underflow_cnt)
  );

  // Burst sequencing, byte capture, retry tracking and checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rem      <= '0;
      r_retry    <= '0;
      r_timeout  <= 1'b0;
      r_sum      <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sum     <= '0;
            r_timeout <= 1'b0;
            r_rem     <= burst_len;
            r_retry   <= '0;
            r_state   <= (burst_len != '0) ? ST_ISSUE : ST_DONE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!fifo_error) begin
            r_out_data <= fifo_dout;
            r_retry    <= '0;
            r_state    <= ST_HOLD;
          end else if (r_retry == RETRY_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_retry <= r_retry + 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_sum   <= r_sum + r_out_data;
            r_rem   <= r_rem - 1'b1;
            r_state <= (r_rem == LEN_W'(1)) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes are pure decodes of the state register, so ren can never
  // coincide with out_valid and reset clears them immediately.
  assign fifo_ren  = (r_state == ST_ISSUE);
  assign out_valid = (r_state == ST_HOLD);
  assign done      = (r_state == ST_DONE);
  assign busy      = (r_state == ST_ISSUE) || (r_state == ST_WAIT) ||
                     (r_state == ST_HOLD);
  assign timeout   = r_timeout;
  assign sum       = r_sum;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_fifo8_burst_reader.sv
// Directed bench: behavioural FIFO_8 plus fifo8_burst_reader.
module tb_fifo8_burst_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] burst_len;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [7:0] sum;
  logic [7:0] underflow_cnt;
  logic       fifo_ren;
  logic [7:0] fifo_dout;
  logic       fifo_error;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // FIFO write side
  logic       wen;
  logic [7:0] din;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  fifo8_burst_reader #(.DATA_W(8), .LEN_W(4), .RETRY_MAX(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .burst_len     (burst_len),
    .busy          (busy),
    .done          (done),
    .timeout       (timeout),
    .sum           (sum),
    .underflow_cnt (underflow_cnt),
    .fifo_ren      (fifo_ren),
    .fifo_dout     (fifo_dout),
    .fifo_error    (fifo_error),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8x8 FIFO: dout/error valid the cycle after ren.
  logic [7:0] mem [0:7];
  logic [2:0] wp, rp;
  logic [3:0] cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 3'd0; rp <= 3'd0; cnt <= 4'd0;
      fifo_dout <= 8'd0; fifo_error <= 1'b0;
    end else begin
      fifo_error <= 1'b0;
      if (fifo_ren) begin
        if (cnt == 4'd0) fifo_error <= 1'b1;
        else begin
          fifo_dout <= mem[rp];
          rp <= rp + 3'd1;
        end
      end
      if (wen && cnt != 4'd8) begin
        mem[wp] <= din;
        wp <= wp + 3'd1;
      end
      cnt <= cnt + ((wen && cnt != 4'd8) ? 4'd1 : 4'd0)
                 - ((fifo_ren && cnt != 4'd0) ? 4'd1 : 4'd0);
    end
  end

  // Stream / read monitor
  int         ren_cnt = 0;
  int         hs_cnt = 0;
  int         valid_cnt = 0;
  int         overlap_cnt = 0;
  logic [7:0] log_b [0:63];
  always @(posedge clk) begin
    if (rst_n) begin
      if (fifo_ren) ren_cnt <= ren_cnt + 1;
      if (out_valid) valid_cnt <= valid_cnt + 1;
      if (fifo_ren && out_valid) overlap_cnt <= overlap_cnt + 1;
      if (out_valid && out_ready) begin
        log_b[hs_cnt[5:0]] <= out_data;
        hs_cnt <= hs_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fifo_write(input logic [7:0] b);
    wen = 1'b1; din = b;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic start_burst(input logic [3:0] len);
    start = 1'b1; burst_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base_r, base_h, base_v;

    rst_n = 1'b0; start = 1'b0; burst_len = 4'd0; out_ready = 1'b1;
    wen = 1'b0; din = 8'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_sum", sum, 0);
    chk("rst_uf", underflow_cnt, 0);
    chk("rst_ren", fifo_ren, 0);
    chk("rst_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 3-byte burst, checksum 56+11+42 = 109
    fifo_write(8'd56); fifo_write(8'd11); fifo_write(8'd42);
    base_r = ren_cnt; base_h = hs_cnt;
    start_burst(4'd3);
    chk("t1_ren_t1", fifo_ren, 1);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_ren_t2", fifo_ren, 0);
    chk("t1_valid_t2", out_valid, 0);
    @(negedge clk);
    chk("t1_valid_t3", out_valid, 1);
    chk("t1_data_t3", out_data, 56);
    wait_done(20, ok);
    chk("t1_done", ok, 1);
    chk("t1_sum", sum, 109);
    chk("t1_timeout", timeout, 0);
    chk("t1_nbytes", hs_cnt - base_h, 3);
    chk("t1_b0", log_b[base_h], 56);
    chk("t1_b1", log_b[base_h + 1], 11);
    chk("t1_b2", log_b[base_h + 2], 42);
    chk("t1_nren", ren_cnt - base_r, 3);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_sum_held", sum, 109);

    // Backpressure: 4 cycles of out_ready=0 in HOLD
    fifo_write(8'd7); fifo_write(8'd9);
    out_ready = 1'b0;
    base_r = ren_cnt; base_h = hs_cnt;
    start_burst(4'd2);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", out_valid, 1);
      chk("t2_hold_data", out_data, 7);
      chk("t2_hold_noren", fifo_ren, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done(20, ok);
    chk("t2_done", ok, 1);
    chk("t2_nbytes", hs_cnt - base_h, 2);
    chk("t2_b0", log_b[base_h], 7);
    chk("t2_b1", log_b[base_h + 1], 9);
    chk("t2_sum", sum, 16);
    chk("t2_nren", ren_cnt - base_r, 2);
    @(negedge clk);

    // Empty FIFO: 4 error reads then abort
    base_r = ren_cnt; base_h = hs_cnt; base_v = valid_cnt;
    chk("t3_uf_before", underflow_cnt, 0);
    start_burst(4'd2);
    wait_done(40, ok);
    chk("t3_done", ok, 1);
    chk("t3_nren", ren_cnt - base_r, 4);
    chk("t3_uf", underflow_cnt, 4);
    chk("t3_timeout", timeout, 1);
    chk("t3_nbytes", hs_cnt - base_h, 0);
    chk("t3_novalid", valid_cnt - base_v, 0);
    chk("t3_sum", sum, 0);
    @(negedge clk);
    chk("t3_timeout_held", timeout, 1);

    // Start on empty, 85 arrives after two error reads
    base_r = ren_cnt; base_h = hs_cnt;
    start_burst(4'd1);
    chk("t4_timeout_clr", timeout, 0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ren_cnt - base_r == 2) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("t4_two_errs", ok, 1);
    fifo_write(8'd85);
    wait_done(20, ok);
    chk("t4_done", ok, 1);
    chk("t4_nbytes", hs_cnt - base_h, 1);
    chk("t4_b0", log_b[base_h], 85);
    chk("t4_uf", underflow_cnt, 6);
    chk("t4_timeout", timeout, 0);
    chk("t4_sum", sum, 85);
    @(negedge clk);

    // Checksum wrap 200+100 = 44; start while busy is ignored
    fifo_write(8'd200); fifo_write(8'd100);
    base_r = ren_cnt; base_h = hs_cnt;
    start_burst(4'd2);
    @(negedge clk);
    start = 1'b1; burst_len = 4'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, ok);
    chk("t5_done", ok, 1);
    chk("t5_sum_wrap", sum, 44);
    chk("t5_nbytes", hs_cnt - base_h, 2);
    chk("t5_nren", ren_cnt - base_r, 2);
    @(negedge clk);
    chk("t5_idle", busy, 0);

    // Zero-length burst: straight to DONE, no ren, sum cleared
    base_r = ren_cnt;
    start_burst(4'd0);
    chk("t5z_done", done, 1);
    chk("t5z_busy", busy, 0);
    chk("t5z_sum", sum, 0);
    chk("t5z_ren", fifo_ren, 0);
    @(negedge clk);
    chk("t5z_done_pulse", done, 0);
    chk("t5z_nren", ren_cnt - base_r, 0);

    // Async reset while a byte is held
    fifo_write(8'd33);
    out_ready = 1'b0;
    start_burst(4'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_valid", out_valid, 1);
    chk("t6_data", out_data, 33);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ren", fifo_ren, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_sum", sum, 0);
    chk("t6_rst_uf", underflow_cnt, 0);
    chk("t6_rst_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("t6_post_valid", out_valid, 0);
    chk("t6_post_busy", busy, 0);

    chk("ren_vs_valid_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
